// File: rtl/glyph_raster_renderer.sv
// Glyph raster renderer: scales one font bitmap by an integer factor
// and streams (x, y, colour) beats over a valid/ready interface.
module glyph_raster_renderer #(
    parameter int FONT_W  = 5,
    parameter int FONT_H  = 7,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int SIZE_W  = 4,
    parameter int COLOR_W = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [FONT_W*FONT_H-1:0] glyph,
    input  logic [X_W-1:0]           origin_x,
    input  logic [Y_W-1:0]           origin_y,
    input  logic [SIZE_W-1:0]        size,
    input  logic                     opaque,
    input  logic [COLOR_W-1:0]       fg_color,
    input  logic [COLOR_W-1:0]       bg_color,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [X_W-1:0]           out_x,
    output logic [Y_W-1:0]           out_y,
    output logic [COLOR_W-1:0]       out_color,
    output logic                     busy,
    output logic                     done
);

    localparam int NB = FONT_W * FONT_H;
    localparam int CW = (FONT_W > 1) ? $clog2(FONT_W) : 1;
    localparam int RW = (FONT_H > 1) ? $clog2(FONT_H) : 1;
    localparam logic [NB-1:0] TOP = NB'(1) << (NB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [NB-1:0]      g_q;
    logic [X_W-1:0]     ox_q;
    logic [Y_W-1:0]     oy_q;
    logic [SIZE_W-1:0]  sm1_q;
    logic               opq_q;
    logic [COLOR_W-1:0] fg_q;
    logic [COLOR_W-1:0] bg_q;
    logic [CW-1:0]      col_q;
    logic [RW-1:0]      row_q;
    logic [SIZE_W-1:0]  sx_q;
    logic [SIZE_W-1:0]  sy_q;

    logic [31:0]    lin;
    logic           pix;
    logic           emit;
    logic           sx_end;
    logic           sy_end;
    logic           col_end;
    logic           row_end;
    logic           fire;
    logic           pix_adv;
    logic [X_W-1:0] sx_scale;
    logic [Y_W-1:0] sy_scale;

    // Decode the current font pixel and the advance conditions.
    always_comb begin
        lin      = 32'(row_q) * 32'(FONT_W) + 32'(col_q);
        pix      = |(g_q & (TOP >> lin));
        emit     = pix | opq_q;
        sx_end   = (sx_q == sm1_q);
        sy_end   = (sy_q == sm1_q);
        col_end  = (col_q == CW'(FONT_W - 1));
        row_end  = (row_q == RW'(FONT_H - 1));
        fire     = (state_q == S_RUN) && emit && out_ready;
        pix_adv  = (state_q == S_RUN) &&
                   (emit ? (out_ready && sx_end && sy_end) : 1'b1);
        sx_scale = X_W'(sm1_q) + X_W'(1);
        sy_scale = Y_W'(sm1_q) + Y_W'(1);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (pix_adv && col_end && row_end) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs come purely from registered state; idle fields read zero.
    always_comb begin
        out_valid = 1'b0;
        out_x     = '0;
        out_y     = '0;
        out_color = '0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_RUN: begin
                busy = 1'b1;
                if (emit) begin
                    out_valid = 1'b1;
                    out_x     = ox_q + X_W'(col_q) * sx_scale + X_W'(sx_q);
                    out_y     = oy_q + Y_W'(row_q) * sy_scale + Y_W'(sy_q);
                    out_color = pix ? fg_q : bg_q;
                end
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Latch the glyph job on start, then walk sub-pixels and font pixels.
    always_ff @(posedge clock) begin
        if (reset) begin
            g_q   <= '0;
            ox_q  <= '0;
            oy_q  <= '0;
            sm1_q <= '0;
            opq_q <= 1'b0;
            fg_q  <= '0;
            bg_q  <= '0;
            col_q <= '0;
            row_q <= '0;
            sx_q  <= '0;
            sy_q  <= '0;
        end else if (state_q == S_IDLE && start) begin
            g_q   <= glyph;
            ox_q  <= origin_x;
            oy_q  <= origin_y;
            sm1_q <= (size == '0) ? '0 : size - SIZE_W'(1);
            opq_q <= opaque;
            fg_q  <= fg_color;
            bg_q  <= bg_color;
            col_q <= '0;
            row_q <= '0;
            sx_q  <= '0;
            sy_q  <= '0;
        end else if (state_q == S_RUN) begin
            if (fire) begin
                if (!sx_end) begin
                    sx_q <= sx_q + SIZE_W'(1);
                end else begin
                    sx_q <= '0;
                    sy_q <= sy_end ? '0 : sy_q + SIZE_W'(1);
                end
            end
            if (pix_adv) begin
                if (col_end) begin
                    col_q <= '0;
                    row_q <= row_end ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_glyph_raster_renderer.sv
// Directed bench for glyph_raster_renderer: timing, scaling,
// wrap-around, backpressure and mid-glyph reset.
module tb_glyph_raster_renderer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [34:0] glyph = '0;
    logic [9:0]  origin_x = '0;
    logic [8:0]  origin_y = '0;
    logic [3:0]  size = '0;
    logic        opaque = 1'b0;
    logic [2:0]  fg_color = '0;
    logic [2:0]  bg_color = '0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [9:0]  out_x;
    logic [8:0]  out_y;
    logic [2:0]  out_color;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail = 0;

    logic [21:0] beats[$];
    logic [21:0] ref_run[$];
    logic [21:0] model[$];
    int done_cyc;
    int first_cyc;
    int junk;
    logic busy1;

    glyph_raster_renderer dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .glyph(glyph),
        .origin_x(origin_x),
        .origin_y(origin_y),
        .size(size),
        .opaque(opaque),
        .fg_color(fg_color),
        .bg_color(bg_color),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_x(out_x),
        .out_y(out_y),
        .out_color(out_color),
        .busy(busy),
        .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] pack(input int x, input int y,
                                         input int c);
        logic [9:0] px;
        logic [8:0] py;
        logic [2:0] pc;
        px = 10'(x);
        py = 9'(y);
        pc = 3'(c);
        return {px, py, pc};
    endfunction

    task automatic run_glyph(input logic [34:0] g, input int ox,
                             input int oy, input int sz, input logic op,
                             input int fg, input int bg, input bit rnd,
                             input int budget);
        bit pv;
        bit pr;
        logic [21:0] pb;
        beats.delete();
        done_cyc = 0;
        first_cyc = 0;
        junk = 0;
        busy1 = 1'b0;
        @(negedge clock);
        glyph = g;
        origin_x = 10'(ox);
        origin_y = 9'(oy);
        size = 4'(sz);
        opaque = op;
        fg_color = 3'(fg);
        bg_color = 3'(bg);
        out_ready = 1'b1;
        start = 1'b1;
        pv = 1'b0;
        pr = 1'b1;
        pb = '0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (cyc == 1) busy1 = busy;
            if (pv && !pr) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_beat", 32'({out_x, out_y, out_color}),
                      32'(pb));
            end
            if (!out_valid && (out_x != 0 || out_y != 0 || out_color != 0))
                junk++;
            pr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = pr;
            if (out_valid && first_cyc == 0) first_cyc = cyc;
            if (out_valid && pr) beats.push_back({out_x, out_y, out_color});
            pv = out_valid;
            pb = {out_x, out_y, out_color};
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        check("done_seen", 32'(done_cyc != 0), 1);
        check("idle_zero", 32'(junk), 0);
        @(negedge clock);
        out_ready = 1'b1;
        check("done_pulse", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    task automatic cmp_queue(input string tag);
        int bad;
        bad = 0;
        check({tag, "_len"}, 32'(beats.size()), 32'(model.size()));
        foreach (model[i]) begin
            if (i >= beats.size() || beats[i] !== model[i]) bad++;
        end
        check({tag, "_seq"}, 32'(bad), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [34:0] gp;
        int bad;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_x", 32'(out_x), 0);
        check("rst_y", 32'(out_y), 0);
        check("rst_color", 32'(out_color), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        reset = 1'b0;

        // single set pixel at row 0 col 0
        run_glyph(35'h1 << 34, 10, 20, 1, 1'b0, 5, 0, 1'b0, 100);
        check("t1_busy", 32'(busy1), 1);
        check("t1_first", 32'(first_cyc), 1);
        check("t1_count", 32'(beats.size()), 1);
        check("t1_beat", 32'(beats.size() > 0 ? beats[0] : 22'h0),
              32'(pack(10, 20, 5)));
        check("t1_done", 32'(done_cyc), 36);

        // opaque blank glyph, size 2
        run_glyph(35'h0, 0, 0, 2, 1'b1, 7, 3, 1'b0, 300);
        check("t2_count", 32'(beats.size()), 140);
        check("t2_done", 32'(done_cyc), 141);
        if (beats.size() == 140) begin
            check("t2_b0", 32'(beats[0]), 32'(pack(0, 0, 3)));
            check("t2_b1", 32'(beats[1]), 32'(pack(1, 0, 3)));
            check("t2_b2", 32'(beats[2]), 32'(pack(0, 1, 3)));
            check("t2_b3", 32'(beats[3]), 32'(pack(1, 1, 3)));
            check("t2_last", 32'(beats[139]), 32'(pack(9, 13, 3)));
        end
        bad = 0;
        foreach (beats[i]) if (beats[i][2:0] != 3'd3) bad++;
        check("t2_colors", 32'(bad), 0);

        // transparent blank glyph: no beats, full scan
        run_glyph(35'h0, 5, 5, 3, 1'b0, 7, 3, 1'b0, 100);
        check("t3_count", 32'(beats.size()), 0);
        check("t3_done", 32'(done_cyc), 36);

        // size 0 treated as 1; pixel at row 1 col 2 is bit 27
        run_glyph(35'h1 << 27, 100, 50, 0, 1'b0, 7, 0, 1'b0, 100);
        check("t4_count", 32'(beats.size()), 1);
        check("t4_beat", 32'(beats.size() > 0 ? beats[0] : 22'h0),
              32'(pack(102, 51, 7)));
        check("t4_done", 32'(done_cyc), 36);

        // x wrap-around across row 0
        run_glyph(35'h1F << 30, 1022, 5, 1, 1'b0, 2, 0, 1'b0, 100);
        model.delete();
        model.push_back(pack(1022, 5, 2));
        model.push_back(pack(1023, 5, 2));
        model.push_back(pack(0, 5, 2));
        model.push_back(pack(1, 5, 2));
        model.push_back(pack(2, 5, 2));
        cmp_queue("t5");

        // opaque mixed glyph, size 2: reference then backpressure
        gp = 35'h4D2B4C3A5;
        model.delete();
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 5; c++)
                for (int sy = 0; sy < 2; sy++)
                    for (int sx = 0; sx < 2; sx++)
                        model.push_back(pack(300 + c * 2 + sx,
                                             200 + r * 2 + sy,
                                             gp[34 - (r * 5 + c)] ? 6 : 1));
        run_glyph(gp, 300, 200, 2, 1'b1, 6, 1, 1'b0, 300);
        cmp_queue("t6_ref");
        check("t6_done", 32'(done_cyc), 141);
        ref_run = beats;
        run_glyph(gp, 300, 200, 2, 1'b1, 6, 1, 1'b1, 2000);
        cmp_queue("t6_bp");
        bad = 0;
        foreach (ref_run[i])
            if (i >= beats.size() || beats[i] !== ref_run[i]) bad++;
        check("t6_vs_ref", 32'(bad), 0);

        // reset in the middle of a glyph
        @(negedge clock);
        glyph = '1;
        origin_x = 10'd40;
        origin_y = 9'd40;
        size = 4'd3;
        opaque = 1'b1;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        check("t7_midrun", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clock);
        check("t7_busy", 32'(busy), 0);
        check("t7_valid", 32'(out_valid), 0);
        check("t7_done", 32'(done), 0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done || out_valid || busy) bad++;
        end
        check("t7_quiet", 32'(bad), 0);
        run_glyph(35'h1 << 34, 7, 9, 1, 1'b1, 4, 2, 1'b0, 100);
        check("t7_count", 32'(beats.size()), 35);
        check("t7_first", 32'(beats.size() > 0 ? beats[0] : 22'h0),
              32'(pack(7, 9, 4)));
        check("t7_second", 32'(beats.size() > 1 ? beats[1] : 22'h0),
              32'(pack(8, 9, 2)));
        check("t7_done_cyc", 32'(done_cyc), 36);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/glyph_raster_renderer.md
# glyph_raster_renderer

Parametrised successor to the single-character renderer. It takes one glyph bitmap of any font size, scales it by a per-glyph integer factor, and streams the resulting screen pixels as (x, y, colour) beats over a valid/ready interface toward the framebuffer writer. Two modes are supported: transparent (only set glyph pixels are emitted) and opaque (cleared pixels are emitted in a background colour). A start/done handshake lets a string or text-layout sequencer issue glyphs back to back.

## Interface
- FONT_W, 5, glyph width in font pixels (≥1)
- FONT_H, 7, glyph height in font pixels (≥1)
- X_W, 10, screen x coordinate width
- Y_W, 9, screen y coordinate width
- SIZE_W, 4, scale factor width
- COLOR_W, 3, colour width
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a glyph; sampled only in IDLE
- glyph  in  FONT_W*FONT_H  bitmap, row-major, MSB = row 0 col 0, LSB = row FONT_H-1 col FONT_W-1
- origin_x  in  X_W  screen x of glyph top-left
- origin_y  in  Y_W  screen y of glyph top-left
- size  in  SIZE_W  scale factor; 0 is treated as 1
- opaque  in  1  1 = emit cleared pixels in bg_color; 0 = skip them
- fg_color  in  COLOR_W  colour for set pixels
- bg_color  in  COLOR_W  colour for cleared pixels (opaque mode)
- out_ready  in  1  downstream accepts the current beat
- out_valid  out  1  beat present
- out_x  out  X_W  beat x coordinate
- out_y  out  Y_W  beat y coordinate
- out_color  out  COLOR_W  beat colour
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when the glyph is complete

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if start=1, latch glyph, origins, effective size s (size, or 1 if 0), opaque and colours; clear counters col, row, sub_x, sub_y; go to RUN. Inputs are not re-sampled after this point.
- RUN: the current font pixel is bit index FONT_W*FONT_H-1-(row*FONT_W+col) of the latched glyph.
  - Emit case (pixel set, or opaque=1): out_valid=1. Colour is fg_color if the pixel is set, otherwise bg_color.
    - out_x = origin_x + col*s + sub_x, truncated modulo 2^X_W.
    - out_y = origin_y + row*s + sub_y, truncated modulo 2^Y_W.
    - Intermediate products use full width; only the final sum truncates.
  - On out_valid & out_ready, advance: sub_x, then sub_y (block raster), then col, then row. Without out_ready, all beat fields hold stable.
  - Skip case (pixel clear and opaque=0): out_valid=0. The whole font pixel is skipped in one cycle; sub counters reset and col/row advance.
  - When the last font pixel's last beat is accepted, or the last pixel is skipped: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored while in RUN or DONE.
- Whenever out_valid=0, out_x, out_y and out_color are 0.
- Reset (any state, including mid-glyph): next cycle IDLE, counters cleared. No done pulse and no further beats.

## Timing
- Reset values: out_valid=0, out_x=0, out_y=0, out_color=0, busy=0, done=0.
- start accepted at edge N: busy=1 and the first beat (or skip) is visible in cycle N+1.
- Outputs depend only on registered state. There is no combinational path from out_ready or any input to an output.
- Throughput with out_ready held at 1: one beat per cycle, one cycle per skipped pixel.
  - Opaque: RUN lasts FONT_W*FONT_H*s² cycles.
  - Transparent: RUN lasts (set bits)*s² + (clear bits) cycles.
- Completion: done rises the cycle after RUN ends. The earliest next start is accepted in the cycle after done, i.e. back in IDLE.
- An all-zero glyph in transparent mode gives FONT_W*FONT_H RUN cycles, no beats, then done.

## Test plan
- Transparent glyph with only bit 34 set, origin (10,20), size 1, fg 5, out_ready=1 → exactly one beat (10,20,5) in cycle N+1. done pulses in cycle N+36.
- Opaque all-zero glyph, size 2, bg 3, origin (0,0) → 140 beats, all colour 3. First four beats are (0,0), (1,0), (0,1), (1,1). Last beat is (9,13).
- size=0 with a single set pixel at row 1 col 2, origin (100,50) → behaves as size 1: one beat at (102,51).
- Backpressure: opaque glyph with out_ready toggled pseudo-randomly → beats unchanged while out_ready=0; beat sequence identical to the out_ready=1 run; no beat duplicated or dropped.
- Wrap-around: origin_x=1022, size 1, row 0 all set → x values 1022, 1023, 0, 1, 2.
- reset asserted mid-RUN → next cycle busy=0, out_valid=0, no done pulse. A subsequent start renders from row 0 col 0.
